// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Contents: FSM state encoding, IO register addresses, status-word bit positions.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitAck = 2'd2,
    StService = 2'd3
  } state_e;

  // IO register select values (adr input)
  localparam logic RegStat = 1'b0;
  localparam logic RegEn   = 1'b1;

  // Status word layout
  localparam int unsigned StatBusyBit  = 31;
  localparam int unsigned StatInSvcBit = 30;
  localparam int unsigned StatCurLsb   = 20;
  localparam int unsigned StatPendLsb  = 0;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder for the interrupt controller.
// Ports:
//   cand_i  candidate lines (pending & enabled)
//   sel_o   index of the lowest set candidate (0 when none)
//   any_o   at least one candidate is set
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] cand_i,
  output logic [3:0]         sel_o,
  output logic               any_o
);

  // Scan from the top down so the lowest set index is the last to write sel_o.
  always_comb begin
    sel_o = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (cand_i[i]) sel_o = 4'(i);
    end
  end

  assign any_o = |cand_i;

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller in front of the RISC5 irq input.
// Captures rising edges per line, picks the lowest-index enabled pending line, pulses the
// CPU irq for one cycle and tracks the intAck/RTI handshake (one interrupt in service).
// An abort request during service pulses intabort and drops back to idle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   irq_in              device interrupt lines (level)
//   stb/wr/adr/data_in  IO bus request; data_out/ack IO response (combinational)
//   intack, rti         CPU handshake inputs
//   abort_req           one-cycle request to abort the in-service handler
//   irq, intabort, busy CPU-side outputs and status
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               stb,
  input  logic               wr,
  input  logic               adr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ack,
  input  logic               intack,
  input  logic               rti,
  input  logic               abort_req,
  output logic               irq,
  output logic               intabort,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] irq_in_q;
  logic [3:0]         cur_q, cur_d;
  logic               intabort_q, intabort_d;

  logic [NUM_IRQ-1:0] rise, cand, sw_set, sw_clr, ack_clr;
  logic [3:0]         sel;
  logic               any;
  logic               wr_stat, wr_en, acked;
  logic [15:0]        pend16, en16;
  logic               unused_data;

  assign unused_data = ^data_in[30:NUM_IRQ];

  // Edge capture and software access
  assign rise    = irq_in & ~irq_in_q;
  assign wr_stat = stb & wr & (adr == RegStat);
  assign wr_en   = stb & wr & (adr == RegEn);
  assign sw_set  = (wr_stat &&  data_in[31]) ? data_in[NUM_IRQ-1:0] : '0;
  assign sw_clr  = (wr_stat && !data_in[31]) ? data_in[NUM_IRQ-1:0] : '0;
  assign acked   = (state_q == StWaitAck) && intack;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      ack_clr[i] = acked && (cur_q == 4'(i));
    end
  end

  // Sets are ORed in last so a same-cycle edge or software set beats any clear.
  assign pending_d = (pending_q & ~(sw_clr | ack_clr)) | rise | sw_set;
  assign enable_d  = wr_en ? data_in[NUM_IRQ-1:0] : enable_q;
  assign cand      = pending_q & enable_q;

  int_prio_enc #(
    .NUM_IRQ(NUM_IRQ)
  ) u_prio_enc (
    .cand_i(cand),
    .sel_o (sel),
    .any_o (any)
  );

  // FSM next state
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    intabort_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          cur_d   = sel;
          state_d = StReq;
        end
      end
      StReq:     state_d = StWaitAck;
      StWaitAck: if (intack) state_d = StService;
      StService: begin
        // rti takes precedence: the handler has already returned.
        if (rti) begin
          state_d = StIdle;
        end else if (abort_req) begin
          state_d    = StIdle;
          intabort_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      enable_q   <= '0;
      irq_in_q   <= '0;
      cur_q      <= '0;
      intabort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      irq_in_q   <= irq_in;
      cur_q      <= cur_d;
      intabort_q <= intabort_d;
    end
  end

  // Outputs
  assign irq      = (state_q == StReq);
  assign busy     = (state_q != StIdle);
  assign intabort = intabort_q;
  assign ack      = stb;

  always_comb begin
    pend16                = '0;
    pend16[NUM_IRQ-1:0]   = pending_q;
    en16                  = '0;
    en16[NUM_IRQ-1:0]     = enable_q;
  end

  always_comb begin
    data_out = '0;
    if (stb && !wr) begin
      if (adr == RegEn) begin
        data_out[15:0] = en16;
      end else begin
        data_out[StatBusyBit]          = busy;
        data_out[StatInSvcBit]         = (state_q == StService);
        data_out[StatCurLsb +: 4]      = cur_q;
        data_out[StatPendLsb +: 16]    = pend16;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  localparam int unsigned NumIrq = 8;
  localparam logic [31:0] Mask = 32'h0000_00ff;

  // Bus operations for the vector table
  localparam int OpNone = 0, OpRs = 1, OpRe = 2, OpWs = 3, OpWe = 4;
  // Control flags for the vector table
  localparam int CIa = 1, CRt = 2, CAb = 4, CRst = 8, CStray = 16;
  // Reference model phases
  localparam int PhIdle = 0, PhReq = 1, PhWait = 2, PhSvc = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NumIrq-1:0] irq_in;
  logic              stb, wr, adr;
  logic [31:0]       data_in, data_out;
  logic              ack, intack, rti, abort_req, irq, intabort, busy;
  logic              stray_ok;

  int unsigned n_cmp, n_bad;

  int_ctrl #(
    .NUM_IRQ(NumIrq)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .stb      (stb),
    .wr       (wr),
    .adr      (adr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .intack   (intack),
    .rti      (rti),
    .abort_req(abort_req),
    .irq      (irq),
    .intabort (intabort),
    .busy     (busy)
  );

  // intAck outside WAIT_ACK (idle or while irq is being raised) is a CPU protocol error.
  a_stray_intack : assert property (@(posedge clk) disable iff (rst || stray_ok)
                                    !(intack && (!busy || irq)))
    else $error("FAIL stray_intack: intack seen while controller idle or requesting");

  typedef struct {
    int          op;
    logic [31:0] din;
    logic [7:0]  irqv;
    int          ctl;
    logic        ei, eb, ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int op, input logic [31:0] din, input logic [7:0] irqv,
                             input int ctl, input logic ei, input logic eb, input logic ea,
                             input logic [31:0] ed);
    vec_t r;
    r.op = op; r.din = din; r.irqv = irqv; r.ctl = ctl;
    r.ei = ei; r.eb = eb; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input int op, input logic [31:0] din, input logic [7:0] irqv,
                       input int ctl);
    stb       = (op != OpNone);
    wr        = (op >= OpWs);
    adr       = (op == OpRe) || (op == OpWe);
    data_in   = din;
    irq_in    = irqv;
    intack    = (ctl & CIa) != 0;
    rti       = (ctl & CRt) != 0;
    abort_req = (ctl & CAb) != 0;
    rst       = (ctl & CRst) != 0;
    stray_ok  = (ctl & CStray) != 0;
  endtask

  task automatic check_outs(input string tag, input logic ei, input logic eb, input logic ea,
                            input logic [31:0] ed);
    chk($sformatf("%s.irq", tag), {31'b0, irq}, {31'b0, ei});
    chk($sformatf("%s.busy", tag), {31'b0, busy}, {31'b0, eb});
    chk($sformatf("%s.intabort", tag), {31'b0, intabort}, {31'b0, ea});
    chk($sformatf("%s.ack", tag), {31'b0, ack}, {31'b0, stb});
    chk($sformatf("%s.data_out", tag), data_out, ed);
  endtask

  // Behavioural reference model
  logic [31:0] m_pend, m_en, m_prev, m_cur;
  int          m_phase;
  logic        m_abort;

  function automatic logic [31:0] lowest(input logic [31:0] m);
    for (int i = 0; i < 32; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] model_dout();
    if (!(stb && !wr)) return 32'h0;
    if (adr) return m_en;
    return {m_phase != PhIdle, m_phase == PhSvc, 6'b0, m_cur[3:0], 4'b0, m_pend[15:0]};
  endfunction

  task automatic model_step();
    logic [31:0] in32, set, clr, nxt_pend, nxt_en;
    if (rst) begin
      m_pend = 0; m_en = 0; m_prev = 0; m_cur = 0; m_phase = PhIdle; m_abort = 0;
      return;
    end
    in32 = {24'b0, irq_in};
    set  = in32 & ~m_prev;
    clr  = 0;
    if (stb && wr && !adr) begin
      if (data_in[31]) set = set | (data_in & Mask);
      else             clr = clr | (data_in & Mask);
    end
    if (m_phase == PhWait && intack) clr = clr | (32'h1 << m_cur);
    nxt_pend = (m_pend & ~clr) | set;
    nxt_en   = (stb && wr && adr) ? (data_in & Mask) : m_en;
    m_abort  = 0;
    case (m_phase)
      PhIdle: if ((m_pend & m_en) != 0) begin
        m_cur   = lowest(m_pend & m_en);
        m_phase = PhReq;
      end
      PhReq:  m_phase = PhWait;
      PhWait: if (intack) m_phase = PhSvc;
      default: begin
        if (rti) m_phase = PhIdle;
        else if (abort_req) begin
          m_phase = PhIdle;
          m_abort = 1;
        end
      end
    endcase
    m_pend = nxt_pend;
    m_en   = nxt_en;
    m_prev = in32;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(OpNone, 0, 0, CRst);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, basic service of line 2
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpWe, 5, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRe, 0, 8'h04, 0,   0, 0, 0, 32'h0000_0005));
    tbl.push_back(v(OpRs, 0, 8'h04, 0,   0, 0, 0, 32'h0000_0004));
    tbl.push_back(v(OpRs, 0, 8'h04, 0,   1, 1, 0, 32'h8020_0004));
    tbl.push_back(v(OpRs, 0, 8'h04, CIa, 0, 1, 0, 32'h8020_0004));
    tbl.push_back(v(OpRs, 0, 8'h04, CRt, 0, 1, 0, 32'hC020_0000));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0020_0000));
    // Simultaneous edges on 0 and 2: line 0 first, then line 2
    tbl.push_back(v(OpRs, 0, 8'h05, 0,   0, 0, 0, 32'h0020_0000));
    tbl.push_back(v(OpRs, 0, 8'h05, 0,   0, 0, 0, 32'h0020_0005));
    tbl.push_back(v(OpRs, 0, 8'h05, 0,   1, 1, 0, 32'h8000_0005));
    tbl.push_back(v(OpRs, 0, 8'h05, CIa, 0, 1, 0, 32'h8000_0005));
    tbl.push_back(v(OpRs, 0, 8'h05, CRt, 0, 1, 0, 32'hC000_0004));
    tbl.push_back(v(OpRs, 0, 8'h05, 0,   0, 0, 0, 32'h0000_0004));
    tbl.push_back(v(OpRs, 0, 8'h05, 0,   1, 1, 0, 32'h8020_0004));
    tbl.push_back(v(OpRs, 0, 8'h05, CIa, 0, 1, 0, 32'h8020_0004));
    tbl.push_back(v(OpRs, 0, 8'h00, CRt, 0, 1, 0, 32'hC020_0000));
    // Disabled line stays pending until enabled
    tbl.push_back(v(OpWe, 0, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h08, 0,   0, 0, 0, 32'h0020_0000));
    tbl.push_back(v(OpRs, 0, 8'h08, 0,   0, 0, 0, 32'h0020_0008));
    tbl.push_back(v(OpWe, 8, 8'h08, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h08, 0,   0, 0, 0, 32'h0020_0008));
    tbl.push_back(v(OpRs, 0, 8'h08, 0,   1, 1, 0, 32'h8030_0008));
    tbl.push_back(v(OpRs, 0, 8'h08, CIa, 0, 1, 0, 32'h8030_0008));
    tbl.push_back(v(OpRs, 0, 8'h00, CRt, 0, 1, 0, 32'hC030_0000));
    // Abort: ignored in WAIT_ACK, honoured in SERVICE, loses to rti
    tbl.push_back(v(OpWe, 2, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   0, 0, 0, 32'h0030_0000));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   0, 0, 0, 32'h0030_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   1, 1, 0, 32'h8010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, CAb, 0, 1, 0, 32'h8010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, CIa, 0, 1, 0, 32'h8010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, CAb, 0, 1, 0, 32'hC010_0000));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 1, 32'h0010_0000));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   0, 0, 0, 32'h0010_0000));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   0, 0, 0, 32'h0010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, 0,   1, 1, 0, 32'h8010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, CIa, 0, 1, 0, 32'h8010_0002));
    tbl.push_back(v(OpRs, 0, 8'h02, CRt | CAb, 0, 1, 0, 32'hC010_0000));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0010_0000));
    // Software set, then clear racing a hardware edge
    tbl.push_back(v(OpWe, 32'h10, 8'h00, 0, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpWs, 32'h8000_0010, 8'h00, 0, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0010_0010));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   1, 1, 0, 32'h8040_0010));
    tbl.push_back(v(OpRs, 0, 8'h00, CIa, 0, 1, 0, 32'h8040_0010));
    tbl.push_back(v(OpRs, 0, 8'h00, CRt, 0, 1, 0, 32'hC040_0000));
    tbl.push_back(v(OpWe, 0, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpWs, 32'h0000_0010, 8'h10, 0, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h10, 0,   0, 0, 0, 32'h0040_0010));
    // Reset during WAIT_ACK, later intack ignored
    tbl.push_back(v(OpWe, 32'h10, 8'h10, 0, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h10, 0,   0, 0, 0, 32'h0040_0010));
    tbl.push_back(v(OpRs, 0, 8'h10, 0,   1, 1, 0, 32'h8040_0010));
    tbl.push_back(v(OpRs, 0, 8'h10, CRst, 0, 1, 0, 32'h8040_0010));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRe, 0, 8'h00, CIa | CStray, 0, 0, 0, 32'h0000_0000));
    tbl.push_back(v(OpRs, 0, 8'h00, 0,   0, 0, 0, 32'h0000_0000));

    foreach (tbl[k]) begin
      drive(tbl[k].op, tbl[k].din, tbl[k].irqv, tbl[k].ctl);
      #1;
      check_outs($sformatf("vec%0d", k), tbl[k].ei, tbl[k].eb, tbl[k].ea, tbl[k].ed);
      @(posedge clk);
      #1;
    end

    // Randomised run against the reference model
    drive(OpNone, 0, 0, CRst);
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < int'(NumIrq); b++) begin
        if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
      end
      stb       = ($urandom_range(0, 2) == 0);
      wr        = 1'($urandom_range(0, 1));
      adr       = 1'($urandom_range(0, 1));
      data_in   = $urandom;
      intack    = (m_phase == PhWait) && ($urandom_range(0, 1) == 1);
      rti       = (m_phase == PhSvc) && ($urandom_range(0, 3) == 0);
      abort_req = ($urandom_range(0, 7) == 0);
      stray_ok  = 1'b0;
      #1;
      check_outs($sformatf("rnd%0d", c), m_phase == PhReq, m_phase != PhIdle, m_abort,
                 model_dout());
      model_step();
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
